// File: rtl/fifo_selfadd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_selfadd_pkg
// Purpose  : Shared state encoding, operation codes and default widths for
//            the FIFO self-add engine.
// Revision : 1.0  initial release
// ============================================================================
package fifo_selfadd_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CNT_W  = 16;

    localparam logic [1:0] MODE_SELFADD = 2'd0;
    localparam logic [1:0] MODE_PLUS1   = 2'd1;
    localparam logic [1:0] MODE_PASS    = 2'd2;
    localparam logic [1:0] MODE_BSWAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/fifo_selfadd_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_selfadd_engine_if
// Purpose  : Input-FIFO pop side and output-FIFO push side of the engine.
// Revision : 1.0  initial release
// ============================================================================
interface fifo_selfadd_engine_if #(
    parameter int DATA_W = 32
);
    logic              data_empty;
    logic              data_rd;
    logic [DATA_W-1:0] data_din;
    logic              data_full;
    logic              data_wr;
    logic [DATA_W-1:0] data_dout;

    modport master (
        input  data_empty, data_din, data_full,
        output data_rd, data_wr, data_dout
    );

    modport slave (
        output data_empty, data_din, data_full,
        input  data_rd, data_wr, data_dout
    );
endinterface
`default_nettype wire

// File: rtl/fifo_selfadd_alu.sv
`default_nettype none
// ============================================================================
// Module   : fifo_selfadd_alu
// Purpose  : Combinational word operation (self-add, plus-one, pass, swap).
// Revision : 1.0  initial release
// ============================================================================
module fifo_selfadd_alu
    import fifo_selfadd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  wire logic [DATA_W-1:0] din,
    input  wire logic [1:0]        mode,
    output logic      [DATA_W-1:0] result,
    output logic                   carry
);

    logic [DATA_W-1:0] w_bswap;
    logic [DATA_W:0]   w_sum;

    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_bswap
        assign w_bswap[8*i +: 8] = din[DATA_W-8-8*i +: 8];
    end

    // One extra bit on the sum exposes the carry of both arithmetic modes.
    always_comb begin
        w_sum = {1'b0, din};
        case (mode)
            MODE_SELFADD: w_sum = {1'b0, din} + {1'b0, din};
            MODE_PLUS1:   w_sum = {1'b0, din} + (DATA_W+1)'(1);
            MODE_PASS:    w_sum = {1'b0, din};
            MODE_BSWAP:   w_sum = {1'b0, w_bswap};
            default:      w_sum = {1'b0, din};
        endcase
    end

    assign result = w_sum[DATA_W-1:0];
    assign carry  = w_sum[DATA_W];

endmodule
`default_nettype wire

// File: rtl/fifo_selfadd_engine.sv
`default_nettype none
// ============================================================================
// Module   : fifo_selfadd_engine
// Purpose  : Pops a word, applies the selected operation, pushes the result.
// Revision : 1.0  initial release
// ============================================================================
module fifo_selfadd_engine
    import fifo_selfadd_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             enable,
    input  wire logic [1:0]       mode,
    input  wire logic             carry_clr,
    fifo_selfadd_engine_if.master bus,
    output logic                  busy,
    output logic [CNT_W-1:0]      word_count,
    output logic                  carry_sticky
);

    state_t            r_state, w_next;
    logic              r_rd, r_wr, r_wr_pend;
    logic [DATA_W-1:0] r_dout, r_hold;
    logic [DATA_W-1:0] w_result, w_push_data;
    logic              w_carry, w_pop, w_push, w_hold_load, w_capture;

    fifo_selfadd_alu #(.DATA_W(DATA_W)) u_alu (
        .din    (bus.data_din),
        .mode   (mode),
        .result (w_result),
        .carry  (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // A pending push blocks the next pop so rd and wr strobes never overlap.
    always_comb begin
        w_next      = r_state;
        w_pop       = 1'b0;
        w_push      = 1'b0;
        w_hold_load = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && !bus.data_empty && !r_wr_pend) begin
                    w_pop  = 1'b1;
                    w_next = RD_WAIT;
                end
            end
            RD_WAIT: w_next = CAPTURE;
            CAPTURE: begin
                w_capture = 1'b1;
                if (bus.data_full) begin
                    w_hold_load = 1'b1;
                    w_next      = HOLD;
                end else begin
                    w_push = 1'b1;
                    w_next = IDLE;
                end
            end
            HOLD: begin
                if (!bus.data_full) begin
                    w_push = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_push_data = (r_state == CAPTURE) ? w_result : r_hold;

    // The push strobe trails the dout update by one cycle through r_wr_pend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd         <= 1'b0;
            r_wr         <= 1'b0;
            r_wr_pend    <= 1'b0;
            r_dout       <= '0;
            r_hold       <= '0;
            word_count   <= '0;
            carry_sticky <= 1'b0;
        end else begin
            r_rd      <= w_pop;
            r_wr_pend <= w_push;
            r_wr      <= r_wr_pend;
            if (w_push)      r_dout <= w_push_data;
            if (w_hold_load) r_hold <= w_result;
            if (r_wr_pend)   word_count <= word_count + CNT_W'(1);
            if (w_capture && w_carry) carry_sticky <= 1'b1;
            else if (carry_clr)       carry_sticky <= 1'b0;
        end
    end

    assign bus.data_rd   = r_rd;
    assign bus.data_wr   = r_wr;
    assign bus.data_dout = r_dout;
    assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: doc/fifo_selfadd_engine.md
FIFO_SELFADD_ENGINE -- requirements
Module: fifo_selfadd_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width.
REQ-002 SHALL have parameter CNT_W, default 16: processed-word counter width.
REQ-003 SHALL have input clock, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have input reset, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input enable, 1 bit: permits starting a new FIFO pop.
REQ-006 SHALL have input mode, 2 bits: operation select (0 self-add, 1 plus-one, 2 pass, 3 byte-swap).
REQ-007 SHALL have input data_empty, 1 bit: empty flag of the input FIFO.
REQ-008 SHALL have output data_rd, 1 bit: registered pop strobe to the input FIFO.
REQ-009 SHALL have input data_din, DATA_W bits: input FIFO dout, valid the cycle after data_rd is high.
REQ-010 SHALL have input data_full, 1 bit: full flag of the output FIFO.
REQ-011 SHALL have output data_wr, 1 bit: registered push strobe to the output FIFO.
REQ-012 SHALL have output data_dout, DATA_W bits: result word to the output FIFO.
REQ-013 SHALL have output busy, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have output word_count, CNT_W bits: results pushed, wraps modulo 2^CNT_W.
REQ-015 SHALL have output carry_sticky, 1 bit: set on any carry-out of self-add or plus-one.
REQ-016 SHALL have input carry_clr, 1 bit: clears carry_sticky.

Function
REQ-017 SHALL implement states IDLE, RD_WAIT, CAPTURE and HOLD.
REQ-018 IDLE: if enable and !data_empty, SHALL drive data_rd=1 for exactly one cycle and go to RD_WAIT; otherwise SHALL stay in IDLE.
REQ-019 RD_WAIT: SHALL go unconditionally to CAPTURE, absorbing the one-cycle FIFO read latency.
REQ-020 CAPTURE: SHALL sample data_din and mode, and compute the result.
REQ-021 CAPTURE with !data_full: SHALL register data_dout=result, pulse data_wr=1 for one cycle and go to IDLE.
REQ-022 CAPTURE with data_full: SHALL hold the result and go to HOLD.
REQ-023 HOLD: SHALL wait while data_full; on the first cycle data_full=0 it SHALL pulse data_wr with the held result and go to IDLE.
REQ-024 Arithmetic SHALL be: mode 0 = din+din and mode 1 = din+1, both truncated to DATA_W, with the bit DATA_W carry feeding carry_sticky.
REQ-025 Arithmetic SHALL be: mode 2 = din; mode 3 = byte-reversed din.
REQ-026 Pop-to-push latency SHALL be 3 cycles from data_rd high to data_wr high when the output FIFO is not full; peak throughput SHALL be one word per 4 cycles.
REQ-027 data_rd and data_wr SHALL never both be high in one cycle, and data_rd SHALL never assert while a result is pending.
REQ-028 word_count SHALL increment in the cycle data_wr is driven high, and SHALL wrap from all-ones to 0.
REQ-029 If a carry and carry_clr occur in the same cycle, carry SHALL win (sticky set).
REQ-030 enable deasserted mid-operation SHALL NOT abort the in-flight word; it SHALL only block the next IDLE pop.
REQ-031 mode changes SHALL affect only words reaching CAPTURE after the change.
REQ-032 data_dout SHALL hold its last pushed value between pushes.

Reset
REQ-033 reset SHALL force state=IDLE and data_rd=0, data_wr=0, data_dout=0, word_count=0, carry_sticky=0, busy=0 immediately, independent of clock.
REQ-034 Reset mid-operation SHALL discard any popped or held word, and no data_wr SHALL follow reset release without a fresh pop.
REQ-035 After reset release, the first data_rd SHALL occur no earlier than the first rising edge with enable=1 and data_empty=0.

Structure
REQ-036 Package fifo_selfadd_pkg SHALL hold the state enum, the mode constants (MODE_SELFADD, MODE_PLUS1, MODE_PASS, MODE_BSWAP) and default widths.
REQ-037 Combinational operation logic SHALL live in sub-module fifo_selfadd_alu (inputs din and mode; outputs result and carry); all sequencing SHALL live in the top.

Verification
REQ-038 Test 1: mode 0, push 0x0000_0005 -> data_dout=0x0000_000A, data_wr 3 cycles after data_rd, word_count=1.
REQ-039 Test 2: mode 0, din 0x8000_0001 -> data_dout=0x0000_0002, carry_sticky=1; then carry_clr -> carry_sticky=0.
REQ-040 Test 3: mode 3, din 0x1122_3344 -> data_dout=0x4433_2211; mode 1, din 0xFFFF_FFFF -> data_dout=0, carry_sticky=1.
REQ-041 Test 4: data_full held high 10 cycles at CAPTURE -> state HOLD, no data_wr, no data_rd; data_full released -> single data_wr with held value.
REQ-042 Test 5: reset pulsed in RD_WAIT -> all outputs 0 at once; no data_wr afterwards until a new pop.
REQ-043 Test 6: 65537 words pushed in mode 2 -> word_count=1 and data_dout equals the final input.
